// File: rtl/alu_muldiv_seq.sv
// Sequencer running W-iteration unsigned shift-add multiply and restoring divide
// on a shared external ALU; results come back as a registered hi/lo pair.
module alu_muldiv_seq #(
    parameter int unsigned W        = 8,
    parameter logic [2:0]  CMD_ADD  = 3'b000,
    parameter logic [2:0]  CMD_SUB  = 3'b110,
    parameter logic [2:0]  CMD_IDLE = 3'b100
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo,
    output logic         dz_err,
    output logic [2:0]   alu_cmd,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_rslt,
    input  logic         alu_flag
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  hi_q, hi_d;        // MUL high partial product / DIV remainder
    logic [W-1:0]  lo_q, lo_d;        // MUL multiplier shift reg / DIV quotient
    logic [W-1:0]  mcand_q, mcand_d;  // MUL multiplicand / DIV divisor
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  res_hi_q, res_hi_d;
    logic [W-1:0]  res_lo_q, res_lo_d;
    logic          dz_err_q, dz_err_d;

    logic [W-1:0]  sum_s;
    logic          sum_c;
    logic [W-1:0]  shifted;
    logic          ge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_err_q <= dz_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_err_d = dz_err_q;
        alu_cmd  = CMD_IDLE;
        alu_a    = '0;
        alu_b    = '0;
        sum_s    = '0;
        sum_c    = 1'b0;
        shifted  = '0;
        ge       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (!op) begin
                        state_d  = S_MUL;
                        hi_d     = '0;
                        lo_d     = opb;
                        mcand_d  = opa;
                        dz_err_d = 1'b0;
                    end else if (opb != '0) begin
                        state_d  = S_DIV;
                        hi_d     = '0;
                        lo_d     = opa;
                        mcand_d  = opb;
                        dz_err_d = 1'b0;
                    end else begin
                        state_d  = S_DONE;
                        res_hi_d = opa;
                        res_lo_d = '1;
                        dz_err_d = 1'b1;
                    end
                end
            end

            S_MUL: begin
                alu_cmd = CMD_ADD;
                alu_a   = hi_q;
                alu_b   = mcand_q;
                // ALU add has no carry out; a wrapped sum is smaller than either addend
                if (lo_q[0]) begin
                    sum_s = alu_rslt;
                    sum_c = (alu_rslt < mcand_q);
                end else begin
                    sum_s = hi_q;
                    sum_c = 1'b0;
                end
                hi_d  = {sum_c, sum_s[W-1:1]};
                lo_d  = {sum_s[0], lo_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    res_hi_d = hi_d;
                    res_lo_d = lo_d;
                end
            end

            S_DIV: begin
                shifted = {hi_q[W-2:0], lo_q[W-1]};
                alu_cmd = CMD_SUB;
                alu_a   = shifted;
                alu_b   = mcand_q;
                // A set remainder MSB means the true shifted value exceeds W bits
                ge      = hi_q[W-1] | ~alu_flag;
                hi_d    = ge ? alu_rslt : shifted;
                lo_d    = {lo_q[W-2:0], ge};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    res_hi_d = hi_d;
                    res_lo_d = lo_d;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign res_hi = res_hi_q;
    assign res_lo = res_lo_q;
    assign dz_err = dz_err_q;

endmodule
